// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port, variable-latency memory between the
// instruction-fetch port and the load/store port, with starvation bound and timeout.
module mem_arbiter #(
  parameter int DSTREAK = 4,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  output logic        i_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        d_stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_t;

  localparam logic [3:0] STREAK_MAX = 4'(DSTREAK);
  localparam logic [7:0] TCNT_LAST  = 8'(TIMEOUT - 1);
  localparam bit         TMO_EN     = (TIMEOUT != 0);

  state_t      state_reg, state_next;
  logic        mem_req_reg, mem_req_next;
  logic        mem_we_reg, mem_we_next;
  logic [31:0] mem_addr_reg, mem_addr_next;
  logic [31:0] mem_wdata_reg, mem_wdata_next;
  logic [31:0] i_rdata_reg, i_rdata_next;
  logic [31:0] d_rdata_reg, d_rdata_next;
  logic        i_ready_reg, i_ready_next;
  logic        d_ready_reg, d_ready_next;
  logic        err_reg, err_next;
  logic [3:0]  streak_reg, streak_next;
  logic [7:0]  tcnt_reg, tcnt_next;

  logic        streak_full;
  logic        pick_d;
  logic        grant;
  logic        timed_out;

  // Data wins ties unless the instruction port has already waited out a full streak.
  assign streak_full = (streak_reg == STREAK_MAX);
  assign pick_d      = d_req & ~(i_req & streak_full);
  assign grant       = en & (i_req | d_req);
  assign timed_out   = TMO_EN && (tcnt_reg == TCNT_LAST);

  always_comb begin
    state_next     = state_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    i_rdata_next   = i_rdata_reg;
    d_rdata_next   = d_rdata_reg;
    i_ready_next   = 1'b0;
    d_ready_next   = 1'b0;
    err_next       = 1'b0;
    streak_next    = streak_reg;
    tcnt_next      = tcnt_reg;

    case (state_reg)
      IDLE: begin
        if (!i_req) begin
          streak_next = 4'd0;
        end
        if (grant) begin
          mem_req_next = 1'b1;
          tcnt_next    = 8'd0;
          if (pick_d) begin
            state_next     = BUSY_D;
            mem_addr_next  = d_addr;
            mem_we_next    = d_we;
            mem_wdata_next = d_wdata;
            if (i_req && !streak_full) begin
              streak_next = streak_reg + 4'd1;
            end
          end else begin
            state_next    = BUSY_I;
            mem_addr_next = i_addr;
            mem_we_next   = 1'b0;
            streak_next   = 4'd0;
          end
        end
      end

      BUSY_I, BUSY_D: begin
        if (mem_ack) begin
          mem_req_next = 1'b0;
          state_next   = IDLE;
          if (state_reg == BUSY_D) begin
            d_rdata_next = mem_rdata;
            d_ready_next = 1'b1;
          end else begin
            i_rdata_next = mem_rdata;
            i_ready_next = 1'b1;
          end
        end else if (timed_out) begin
          // Abandon the access: complete it toward the CPU with zero data and err.
          mem_req_next = 1'b0;
          state_next   = IDLE;
          err_next     = 1'b1;
          tcnt_next    = 8'd0;
          if (state_reg == BUSY_D) begin
            d_rdata_next = 32'd0;
            d_ready_next = 1'b1;
          end else begin
            i_rdata_next = 32'd0;
            i_ready_next = 1'b1;
          end
        end else if (tcnt_reg != 8'hFF) begin
          tcnt_next = tcnt_reg + 8'd1;
        end
      end

      default: begin
        state_next   = IDLE;
        mem_req_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= 32'd0;
      mem_wdata_reg <= 32'd0;
      i_rdata_reg   <= 32'd0;
      d_rdata_reg   <= 32'd0;
      i_ready_reg   <= 1'b0;
      d_ready_reg   <= 1'b0;
      err_reg       <= 1'b0;
      streak_reg    <= 4'd0;
      tcnt_reg      <= 8'd0;
    end else begin
      state_reg     <= state_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      i_rdata_reg   <= i_rdata_next;
      d_rdata_reg   <= d_rdata_next;
      i_ready_reg   <= i_ready_next;
      d_ready_reg   <= d_ready_next;
      err_reg       <= err_next;
      streak_reg    <= streak_next;
      tcnt_reg      <= tcnt_next;
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign i_rdata   = i_rdata_reg;
  assign d_rdata   = d_rdata_reg;
  assign i_ready   = i_ready_reg;
  assign d_ready   = d_ready_reg;
  assign err       = err_reg;

  assign i_stall = i_req & ~i_ready_reg;
  assign d_stall = d_req & ~d_ready_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a behavioural memory answers mem_req after a
// programmable delay and a monitor checks every ready pulse against queued expectations.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        i_stall;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        d_stall;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    bit          is_d;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   ack_delay = 0;
  int   busy_cnt = 0;
  bit   ack_force = 1'b0;

  mem_arbiter #(.DSTREAK(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .en(en),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready), .i_stall(i_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .d_stall(d_stall), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rdata_of(input logic [31:0] addr);
    if (addr == 32'h1C00_0000) return 32'h0280_0000;
    return (addr ^ 32'hA5A5_0000) + 32'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and update the memory model's response.
  task automatic tick();
    @(negedge clk);
    if (mem_req) busy_cnt++;
    else busy_cnt = 0;
    mem_ack   = ack_force || (mem_req && ack_delay >= 0 && busy_cnt == ack_delay + 1);
    mem_rdata = rdata_of(mem_addr);
  endtask

  task automatic push_exp(input bit is_d, input logic [31:0] rdata, input bit e_err);
    exp_t e;
    e.is_d  = is_d;
    e.rdata = rdata;
    e.err   = e_err;
    sb.push_back(e);
  endtask

  task automatic run_single(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input int delay, input bit exp_err,
                            output int nreq);
    bit done;
    nreq = 0;
    done = 1'b0;
    ack_delay = delay;
    push_exp(is_d, exp_err ? 32'd0 : rdata_of(addr), exp_err);
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr;
    end
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      if (mem_req) begin
        nreq++;
        check("mem_addr", mem_addr, addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, is_d & we});
        if (is_d && we) check("mem_wdata", mem_wdata, wdata);
      end
      if (is_d ? d_ready : i_ready) done = 1'b1;
    end
    if (!done) check("ready_wait", 32'd0, 32'd1);
    if (is_d) d_req = 1'b0;
    else i_req = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_i_rdata"}, i_rdata, 32'd0);
    check({tag, "_d_rdata"}, d_rdata, 32'd0);
    check({tag, "_i_ready"}, {31'd0, i_ready}, 32'd0);
    check({tag, "_d_ready"}, {31'd0, d_ready}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // Monitor: every ready pulse consumes the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (i_ready || d_ready)) begin
        check("ready_excl", {31'd0, i_ready & d_ready}, 32'd0);
        check("req_in_ready", {31'd0, mem_req}, 32'd0);
        if (sb.size() == 0) begin
          check("sb_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("port_is_d", {31'd0, d_ready}, {31'd0, e.is_d});
          check("rdata", d_ready ? d_rdata : i_rdata, e.rdata);
          check("err", {31'd0, err}, {31'd0, e.err});
          $display("[TB] txn %s rdata=0x%08h err=%0d", d_ready ? "D" : "I",
                   d_ready ? d_rdata : i_rdata, err);
        end
      end
    end
  end

  initial begin
    int nreq;
    int icnt;
    int dcnt;
    bit done;
    rst = 1'b1; en = 1'b1;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;

    // First fetch: ack in the first mem_req cycle.
    ack_delay = 0;
    i_req = 1'b1; i_addr = 32'h1C00_0000;
    push_exp(1'b0, 32'h0280_0000, 1'b0);
    tick();
    check("t1_mem_req_c1", {31'd0, mem_req}, 32'd1);
    check("t1_mem_addr", mem_addr, 32'h1C00_0000);
    check("t1_i_stall_c1", {31'd0, i_stall}, 32'd1);
    tick();
    check("t1_i_ready_c2", {31'd0, i_ready}, 32'd1);
    check("t1_d_ready_c2", {31'd0, d_ready}, 32'd0);
    check("t1_i_stall_c2", {31'd0, i_stall}, 32'd0);
    i_req = 1'b0;

    // Both ports saturated: data streak of 4, then one fetch.
    ack_delay = 0;
    for (int n = 0; n < 10; n++) begin
      if (n == 4 || n == 9) push_exp(1'b0, rdata_of(32'h0000_2000), 1'b0);
      else push_exp(1'b1, rdata_of(32'h0000_0300), 1'b0);
    end
    i_req = 1'b1; i_addr = 32'h0000_2000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
    icnt = 0; dcnt = 0; done = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      tick();
      if (i_req && !i_ready) check("streak_i_stall", {31'd0, i_stall}, 32'd1);
      if (d_ready) begin
        dcnt++;
        if (dcnt == 8) d_req = 1'b0;
      end
      if (i_ready) begin
        icnt++;
        if (icnt == 2) i_req = 1'b0;
      end
      done = (icnt == 2) && (dcnt == 8);
    end
    if (!done) check("streak_wait", 32'd0, 32'd1);
    i_req = 1'b0; d_req = 1'b0;

    // Store with a slow ack: request fields held for 6 cycles.
    run_single(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 5, 1'b0, nreq);
    check("store_req_cycles", nreq, 32'd6);

    // Load that never gets acked: times out after 8 cycles.
    run_single(1'b1, 1'b0, 32'h0000_0400, 32'd0, -1, 1'b1, nreq);
    check("tmo_req_cycles", nreq, 32'd8);
    run_single(1'b0, 1'b0, 32'h1C00_0040, 32'd0, 1, 1'b0, nreq);
    check("after_tmo_req_cycles", nreq, 32'd2);

    // Reset in the middle of a data access, late ack afterwards.
    ack_delay = -1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500;
    tick();
    tick();
    check("rst_busy_mem_req", {31'd0, mem_req}, 32'd1);
    tick();
    tick();
    rst = 1'b1; d_req = 1'b0; ack_force = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    ack_force = 1'b0;
    tick();
    check("late_ack_i_ready", {31'd0, i_ready}, 32'd0);
    check("late_ack_d_ready", {31'd0, d_ready}, 32'd0);
    check("late_ack_err", {31'd0, err}, 32'd0);
    check("late_ack_mem_req", {31'd0, mem_req}, 32'd0);

    // Enable gating: no grant while en is low, in-flight access still finishes.
    ack_delay = 3;
    en = 1'b0; i_req = 1'b1; i_addr = 32'h0000_0600;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_low_no_req", {31'd0, mem_req}, 32'd0);
    end
    push_exp(1'b0, rdata_of(32'h0000_0600), 1'b0);
    en = 1'b1;
    tick();
    check("en_grant_mem_req", {31'd0, mem_req}, 32'd1);
    en = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      tick();
      done = i_ready;
    end
    if (!done) check("en_ready_wait", 32'd0, 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_low_after", {31'd0, mem_req}, 32'd0);
    end
    i_req = 1'b0; en = 1'b1;

    repeat (3) tick();
    check("sb_drain", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
